qbus_slave_seq: RTL

Parametrised QBUS slave-cycle sequencer that replaces ad-hoc reply logic in top-level designs.
- Serves NDEV register devices (switch register, RKV11, future controllers) from one synchronous FSM on clk20.
- Synchronizes RDIN/RDOUT and the per-device match/vector requests, then arbitrates by fixed priority.
- Drives TRPLY and the Am2908 transceiver controls (DALtx/DALst/DALbe) with a programmable settle delay for ribbon-cable buses.
- Issues one-clock per-device read/write strobes.

---
 rtl/qbus_slave_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/qbus_slave_seq.sv
// qbus_slave_seq: QBUS slave-cycle sequencer serving NDEV register devices on clk20
//   in : clk20, reset_L (async, active low), RDIN, RDOUT, dev_match[NDEV], dev_vector[NDEV], dev_tdl[16*NDEV]
//   out: TDAL[22], TRPLY, DALtx, DALst, DALbe, rd_strobe[NDEV], wr_strobe[NDEV], sel[SW], busy
module qbus_slave_seq #(
   parameter int NDEV   = 4,
   parameter int SETTLE = 2,
   parameter int SW     = 3
) (
   input  logic                 clk20,
   input  logic                 reset_L,
   input  logic                 RDIN,
   input  logic                 RDOUT,
   input  logic [NDEV-1:0]      dev_match,
   input  logic [NDEV-1:0]      dev_vector,
   input  logic [16*NDEV-1:0]   dev_tdl,
   output logic [21:0]          TDAL,
   output logic                 TRPLY,
   output logic                 DALtx,
   output logic                 DALst,
   output logic                 DALbe,
   output logic [NDEV-1:0]      rd_strobe,
   output logic [NDEV-1:0]      wr_strobe,
   output logic [SW-1:0]        sel,
   output logic                 busy
);
   typedef enum logic [2:0] {IDLE, RD_SETTLE, RD_REPLY, WR_REPLY, VEC_SETTLE, VEC_REPLY} state_t;
   localparam int SN = 2*NDEV + 2;
   state_t          state;
   logic [SN-1:0]   s1, s2;
   logic            s_rdin, s_rdout, hold, drop;
   logic [NDEV-1:0] s_match, s_vector, sel_oh, nxt_oh;
   logic [SW-1:0]   m_idx, v_idx, nxt_idx;
   logic [15:0]     word;
   logic [3:0]      cnt;
   assign {s_rdin, s_rdout, s_match, s_vector} = s2;
   always_ff @(posedge clk20 or negedge reset_L)
      if (!reset_L) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {RDIN, RDOUT, dev_match, dev_vector};
         s2 <= s1;
      end
   // Lowest asserted index wins; once busy the latched sel drives data and strobes.
   always_comb begin
      m_idx = '0;
      v_idx = '0;
      for (int i = NDEV-1; i >= 0; i--) begin
         m_idx = s_match[i] ? SW'(i) : m_idx;
         v_idx = s_vector[i] ? SW'(i) : v_idx;
      end
      nxt_idx = (state != IDLE) ? sel : (|s_match ? m_idx : v_idx);
      sel_oh = '0;
      nxt_oh = '0;
      word = '0;
      for (int i = 0; i < NDEV; i++) begin
         sel_oh[i] = (sel == SW'(i));
         nxt_oh[i] = (nxt_idx == SW'(i));
         word = nxt_oh[i] ? dev_tdl[16*i +: 16] : word;
      end
      hold = (state == VEC_SETTLE || state == VEC_REPLY) ? |(s_vector & sel_oh) : |(s_match & sel_oh);
      drop = (state != IDLE) && (!hold ||
             ((state == RD_REPLY || state == VEC_REPLY) && !s_rdin) ||
             (state == WR_REPLY && !s_rdout));
   end
   always_ff @(posedge clk20 or negedge reset_L)
      if (!reset_L) begin
         state <= IDLE;
         cnt <= '0;
         sel <= '0;
         TDAL <= '0;
         {TRPLY, DALtx, DALst, DALbe, busy} <= '0;
         rd_strobe <= '0;
         wr_strobe <= '0;
      end else begin
         rd_strobe <= '0;
         wr_strobe <= '0;
         if (drop) begin
            state <= IDLE;
            TDAL <= '0;
            {TRPLY, DALtx, DALst, DALbe, busy} <= '0;
         end else case (state)
            IDLE:
               if (s_rdin && (|s_match || |s_vector)) begin
                  state <= |s_match ? RD_SETTLE : VEC_SETTLE;
                  cnt <= 4'(SETTLE);
                  sel <= nxt_idx;
                  TDAL <= {6'b0, word};
                  DALtx <= 1'b1;
                  busy <= 1'b1;
               end else if (s_rdout && |s_match) begin
                  state <= WR_REPLY;
                  sel <= nxt_idx;
                  TRPLY <= 1'b1;
                  wr_strobe <= nxt_oh;
                  busy <= 1'b1;
               end
            RD_SETTLE, VEC_SETTLE: begin
               TDAL <= {6'b0, word};
               cnt <= cnt - 4'd1;
               if (cnt == 4'd0) begin
                  state <= (state == RD_SETTLE) ? RD_REPLY : VEC_REPLY;
                  {TRPLY, DALst, DALbe} <= '1;
                  rd_strobe <= sel_oh;
               end
            end
            RD_REPLY, VEC_REPLY: TDAL <= {6'b0, word};
            default: ;
         endcase
      end
endmodule
